// File: rtl/alu_pkg.sv
// ALU control codes shared between the ALU decoder and the iterative divider.
package alu_pkg;

  localparam int ALU_CTRL_W = 5;

  localparam logic [ALU_CTRL_W-1:0] ALU_DIV  = 5'b01110;
  localparam logic [ALU_CTRL_W-1:0] ALU_DIVU = 5'b01111;
  localparam logic [ALU_CTRL_W-1:0] ALU_REM  = 5'b10000;
  localparam logic [ALU_CTRL_W-1:0] ALU_REMU = 5'b10001;

  function automatic logic is_div_op(input logic [ALU_CTRL_W-1:0] code);
    return (code == ALU_DIV) || (code == ALU_DIVU) ||
           (code == ALU_REM) || (code == ALU_REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left and trial-subtract the divisor.
module div_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] rem,
  input  logic [DATA_WIDTH-1:0] quo,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] rem_next,
  output logic [DATA_WIDTH-1:0] quo_next
);

  logic [DATA_WIDTH:0] shifted;
  logic [DATA_WIDTH:0] diff;

  // The extra bit keeps the shifted partial remainder exact, so the sign of diff is the compare result.
  always_comb begin
    shifted = {rem, quo[DATA_WIDTH-1]};
    diff    = shifted - {1'b0, divisor};
    if (!diff[DATA_WIDTH]) begin
      rem_next = diff[DATA_WIDTH-1:0];
      quo_next = {quo[DATA_WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[DATA_WIDTH-1:0];
      quo_next = {quo[DATA_WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU; stalls the pipeline while iterating.
module div_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ALUCTR_WIDTH = 5,
  parameter int CNT_WIDTH    = $clog2(DATA_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [ALUCTR_WIDTH-1:0] alu_ctrl,
  input  logic [DATA_WIDTH-1:0]   op_a,
  input  logic [DATA_WIDTH-1:0]   op_b,
  input  logic                    flush,
  output logic                    stall,
  output logic                    busy,
  output logic                    result_valid,
  output logic [DATA_WIDTH-1:0]   result
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

  localparam logic [DATA_WIDTH-1:0] INT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  div_state_t            state;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [DATA_WIDTH-1:0] rem, quo, divisor;
  logic [DATA_WIDTH-1:0] rem_next, quo_next;
  logic                  is_rem, is_signed, sign_q, sign_r;

  logic                  div_op, op_signed, op_rem, accept, div_zero, overflow;
  logic [DATA_WIDTH-1:0] abs_a, abs_b, special_result, final_result;

  div_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (divisor),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // INT_MIN magnitude wraps to itself, which is still correct as an unsigned operand.
  always_comb begin
    div_op    = is_div_op(alu_ctrl);
    op_signed = (alu_ctrl == ALU_DIV) || (alu_ctrl == ALU_REM);
    op_rem    = (alu_ctrl == ALU_REM) || (alu_ctrl == ALU_REMU);
    accept    = valid_in & div_op & ~flush & (state == IDLE);
    div_zero  = (op_b == '0);
    overflow  = op_signed & (op_a == INT_MIN) & (op_b == '1);
    abs_a     = (op_signed & op_a[DATA_WIDTH-1]) ? -op_a : op_a;
    abs_b     = (op_signed & op_b[DATA_WIDTH-1]) ? -op_b : op_b;
    if (div_zero) special_result = op_rem ? op_a : '1;
    else          special_result = op_rem ? '0 : INT_MIN;
    if (is_rem) final_result = (is_signed & sign_r) ? -rem_next : rem_next;
    else        final_result = (is_signed & sign_q) ? -quo_next : quo_next;
    stall = accept | (state == CALC);
    busy  = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      rem          <= '0;
      quo          <= '0;
      divisor      <= '0;
      is_rem       <= 1'b0;
      is_signed    <= 1'b0;
      sign_q       <= 1'b0;
      sign_r       <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              if (div_zero || overflow) begin
                result       <= special_result;
                result_valid <= 1'b1;
                state        <= DONE;
              end else begin
                quo       <= abs_a;
                rem       <= '0;
                divisor   <= abs_b;
                is_rem    <= op_rem;
                is_signed <= op_signed;
                sign_q    <= op_a[DATA_WIDTH-1] ^ op_b[DATA_WIDTH-1];
                sign_r    <= op_a[DATA_WIDTH-1];
                cnt       <= CNT_WIDTH'(DATA_WIDTH - 1);
                state     <= CALC;
              end
            end
          end
          CALC: begin
            rem <= rem_next;
            quo <= quo_next;
            if (cnt == '0) begin
              result       <= final_result;
              result_valid <= 1'b1;
              state        <= DONE;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed and randomised checks of div_sequencer latency, results, flush and reset behaviour.
module tb_div_sequencer;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [4:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        result_valid;
  logic [31:0] result;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [4:0] C_DIV  = 5'b01110;
  localparam logic [4:0] C_DIVU = 5'b01111;
  localparam logic [4:0] C_REM  = 5'b10000;
  localparam logic [4:0] C_REMU = 5'b10001;

  div_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_in     (valid_in),
    .alu_ctrl     (alu_ctrl),
    .op_a         (op_a),
    .op_b         (op_b),
    .flush        (flush),
    .stall        (stall),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] c, input logic [31:0] a,
                               input logic [31:0] b, input logic f);
    valid_in = v;
    alu_ctrl = c;
    op_a     = a;
    op_b     = b;
    flush    = f;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  function automatic logic [31:0] ref_model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
    logic sgn, rm;
    sgn = (c == C_DIV) || (c == C_REM);
    rm  = (c == C_REM) || (c == C_REMU);
    if (b == 32'd0) return rm ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return rm ? 32'd0 : 32'h8000_0000;
    if (sgn) return rm ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return rm ? a % b : a / b;
  endfunction

  // Issue one op in the current cycle and follow it to DONE and back to IDLE.
  task automatic runOp(input string tag, input logic [4:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_result, input int exp_lat);
    int   cyc;
    logic stall_ok;
    applyStimulus(1'b1, c, a, b, 1'b0);
    checkOutput({tag, " stall@accept"}, 32'(stall), 32'd1);
    tick();
    valid_in = 1'b0;
    cyc      = 1;
    stall_ok = 1'b1;
    while (!result_valid && cyc < 40) begin
      if (!stall) stall_ok = 1'b0;
      tick();
      cyc++;
    end
    checkOutput({tag, " latency"}, 32'(cyc), 32'(exp_lat));
    checkOutput({tag, " result"}, result, exp_result);
    checkOutput({tag, " stall held"}, 32'(stall_ok), 32'd1);
    checkOutput({tag, " stall@done"}, 32'(stall), 32'd0);
    tick();
    checkOutput({tag, " busy@idle"}, 32'(busy), 32'd0);
    checkOutput({tag, " valid pulse"}, 32'(result_valid), 32'd0);
    checkOutput({tag, " result hold"}, result, exp_result);
  endtask

  initial begin
    logic        seen;
    logic [4:0]  rc;
    logic [31:0] ra, rb, rexp;
    logic [4:0]  codes [4];
    codes[0] = C_DIV; codes[1] = C_DIVU; codes[2] = C_REM; codes[3] = C_REMU;

    rst_n = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
    tick();
    checkOutput("reset stall", 32'(stall), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset valid", 32'(result_valid), 32'd0);
    checkOutput("reset result", result, 32'd0);
    rst_n = 1'b1;
    tick();

    runOp("DIVU 100/7", C_DIVU, 32'd100, 32'd7, 32'd14, 33);
    runOp("REMU 100/7", C_REMU, 32'd100, 32'd7, 32'd2, 33);
    runOp("DIV -7/2", C_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    runOp("REM -7/2", C_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    runOp("REM 7/-2", C_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    runOp("DIV x/0", C_DIV, 32'd55, 32'd0, 32'hFFFF_FFFF, 1);
    runOp("REMU 1234/0", C_REMU, 32'h0000_1234, 32'd0, 32'h0000_1234, 1);
    runOp("DIV ovf", C_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    runOp("REM ovf", C_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    runOp("DIV INT_MIN/3", C_DIV, 32'h8000_0000, 32'd3, 32'hD555_5556, 33);

    // Flush during CALC.
    applyStimulus(1'b1, C_DIVU, 32'd1000, 32'd3, 1'b0);
    tick();
    valid_in = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    #1;
    checkOutput("flush stall@10", 32'(stall), 32'd1);
    tick();
    flush = 1'b0;
    #1;
    checkOutput("flush busy@11", 32'(busy), 32'd0);
    checkOutput("flush stall@11", 32'(stall), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (result_valid) seen = 1'b1;
      tick();
    end
    checkOutput("flush no valid", 32'(seen), 32'd0);
    runOp("DIVU max/1", C_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);

    // Flush coinciding with an accept.
    applyStimulus(1'b1, C_DIV, 32'd9, 32'd3, 1'b1);
    checkOutput("flush+accept stall", 32'(stall), 32'd0);
    tick();
    applyStimulus(1'b0, C_DIV, 32'd9, 32'd3, 1'b0);
    checkOutput("flush+accept busy", 32'(busy), 32'd0);

    // Non-div code.
    applyStimulus(1'b1, 5'b00000, 32'd9, 32'd3, 1'b0);
    checkOutput("nondiv stall", 32'(stall), 32'd0);
    tick();
    checkOutput("nondiv busy", 32'(busy), 32'd0);
    applyStimulus(1'b0, 5'b00000, 32'd0, 32'd0, 1'b0);

    // Reset mid-operation.
    applyStimulus(1'b1, C_DIVU, 32'd500, 32'd5, 1'b0);
    tick();
    valid_in = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    checkOutput("rst mid stall", 32'(stall), 32'd0);
    checkOutput("rst mid busy", 32'(busy), 32'd0);
    checkOutput("rst mid valid", 32'(result_valid), 32'd0);
    checkOutput("rst mid result", result, 32'd0);
    tick();
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (result_valid) seen = 1'b1;
      tick();
    end
    checkOutput("rst no valid", 32'(seen), 32'd0);

    // Random ops against the reference model.
    for (int k = 0; k < 16; k++) begin
      rc = codes[$urandom_range(3, 0)];
      ra = $urandom;
      rb = ($urandom_range(7, 0) == 0) ? 32'd0 : ($urandom >> $urandom_range(28, 0));
      rexp = ref_model(rc, ra, rb);
      runOp($sformatf("rand%0d", k), rc, ra, rb, rexp,
            (rb == 32'd0 || ((rc == C_DIV || rc == C_REM) && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)) ? 1 : 33);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
